// File: rtl/alsu_cmd_driver.sv
// Command-word initiator for the ALSU: drives its operand/control pins, captures
// the result after the ALSU pipeline latency and returns it on a valid/ready channel.
module alsu_cmd_driver #(
  parameter int LATENCY      = 2,
  parameter int BLINK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic        prot_err,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic [2:0]  alsu_opcode,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_direction,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds
);

  localparam int CNT_MAX = (LATENCY > BLINK_CYCLES) ? LATENCY : BLINK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, BLINK, RESP} state_t;

  state_t        state, state_nxt;
  logic [15:0]   cmd_q;
  logic          inv_q;
  logic [CW-1:0] cnt;
  logic          led_seen;

  logic        accept, cmd_invalid, drive, track, seen_now, wait_done, blink_done;
  logic [15:0] pins;

  // Reduction ops are only defined for the AND/XOR opcodes (000/001).
  assign cmd_invalid = (cmd_data[8:7] == 2'b11) ||
                       ((cmd_data[12] || cmd_data[13]) && (cmd_data[8:7] != 2'b00));

  assign cmd_ready  = (state == IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign rsp_valid  = (state == RESP);
  assign drive      = (state == ISSUE) || (state == WAIT);
  assign track      = drive || (state == BLINK);
  assign seen_now   = led_seen || (track && (alsu_leds != '0));
  assign wait_done  = (state == WAIT)  && (cnt == CW'(LATENCY - 1));
  assign blink_done = (state == BLINK) && (cnt == CW'(BLINK_CYCLES - 1));

  // The ALSU samples direction combinationally, so pins hold through all of WAIT.
  assign pins           = drive ? cmd_q : '0;
  assign alsu_A         = pins[2:0];
  assign alsu_B         = pins[5:3];
  assign alsu_opcode    = pins[8:6];
  assign alsu_cin       = pins[9];
  assign alsu_serial_in = pins[10];
  assign alsu_direction = pins[11];
  assign alsu_red_op_A  = pins[12];
  assign alsu_red_op_B  = pins[13];
  assign alsu_bypass_A  = pins[14];
  assign alsu_bypass_B  = pins[15];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = ISSUE;
      ISSUE:                   state_nxt = WAIT;
      WAIT:    if (wait_done)  state_nxt = inv_q ? BLINK : RESP;
      BLINK:   if (blink_done) state_nxt = RESP;
      RESP:    if (rsp_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= '0;
      inv_q    <= 1'b0;
      cnt      <= '0;
      led_seen <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      prot_err <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q    <= cmd_data;
        inv_q    <= cmd_invalid;
        led_seen <= 1'b0;
      end else if (track) begin
        led_seen <= seen_now;
      end

      if (state != state_nxt)                 cnt <= '0;
      else if (state == WAIT || state == BLINK) cnt <= cnt + CW'(1);

      if (wait_done && !inv_q) begin
        rsp_data <= alsu_out;
        rsp_err  <= 1'b0;
        if (seen_now) prot_err <= 1'b1;
      end
      if (blink_done) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
        if (!seen_now) prot_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Bench for alsu_cmd_driver: a behavioural ALSU model answers the pins, and an
// expected response per command is computed from the command rules and checked.
module tb_alsu_cmd_driver;

  localparam int LAT   = 2;
  localparam int BLINK = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, prot_err;
  logic [15:0] cmd_data, alsu_leds;
  logic [5:0]  rsp_data, alsu_out;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_direction;
  logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;

  int checks = 0;
  int errors = 0;
  int led_mode = 0;     // 0: ALSU-like, 1: tied to 0, 2: stuck nonzero
  logic prot_exp = 1'b0;

  always #5 clk = ~clk;

  alsu_cmd_driver #(.LATENCY(LAT), .BLINK_CYCLES(BLINK)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .prot_err(prot_err),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds)
  );

  logic [15:0] pins;
  assign pins = {alsu_bypass_B, alsu_bypass_A, alsu_red_op_B, alsu_red_op_A,
                 alsu_direction, alsu_serial_in, alsu_cin, alsu_opcode, alsu_B, alsu_A};

  function automatic logic [15:0] mk(int a, int b, int op, int cin, int si, int dir,
                                     int ra, int rb, int ba, int bb);
    mk = 16'((bb << 15) | (ba << 14) | (rb << 13) | (ra << 12) | (dir << 11) |
             (si << 10) | (cin << 9) | (op << 6) | (b << 3) | a);
  endfunction

  function automatic logic is_invalid(logic [15:0] c);
    int op;
    op = int'(c[8:6]);
    is_invalid = (op >= 6) || ((c[12] || c[13]) && op > 1);
  endfunction

  // ALSU result for a command word, with direction supplied separately.
  function automatic logic [5:0] alsu_f(logic [15:0] c, logic dir);
    int a, b, cin, si;
    a = int'(c[2:0]); b = int'(c[5:3]); cin = int'(c[9]); si = int'(c[10]);
    if (c[14]) return 6'(a);
    if (c[15]) return 6'(b);
    case (int'(c[8:6]))
      0: return c[12] ? 6'(a == 7) : c[13] ? 6'(b == 7) : 6'(a & b);
      1: return c[12] ? 6'($countones(c[2:0]) % 2) : c[13] ? 6'($countones(c[5:3]) % 2) : 6'(a ^ b);
      2: return 6'(a + b + cin);
      3: return 6'(a * b);
      4: return dir ? 6'(((a * 2) % 8) + si) : 6'(si * 4 + a / 2);
      5: return dir ? 6'(((a * 2) % 8) + a / 4) : 6'((a % 2) * 4 + a / 2);
      default: return 6'd0;
    endcase
  endfunction

  // Two-stage ALSU model: inputs registered, result registered, direction read live.
  logic [15:0] s1;
  always @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      alsu_out <= '0;
    end else begin
      s1       <= pins;
      alsu_out <= alsu_f(s1, alsu_direction);
    end
  end
  assign alsu_leds = (led_mode == 1) ? 16'h0000 :
                     (led_mode == 2) ? 16'hFFFF :
                     (is_invalid(s1) ? 16'hA5A5 : 16'h0000);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [15:0] c, input int hold);
    int cyc;
    logic inv;
    logic [5:0] exp_d;
    logic [5:0] d0;
    logic e0;
    inv   = is_invalid(c);
    exp_d = inv ? 6'd0 : alsu_f(c, c[11]);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data  = c;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 16'($urandom);
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      if (cyc == 0)                check("pins_issue", pins, c);
      if (cyc == 1)                check("busy_not_ready", cmd_ready, 0);
      if (cyc == LAT)              check("pins_last_wait", pins, c);
      if (inv && cyc == LAT + 1)   check("pins_blink_nop", pins, 0);
      tick();
      cyc++;
    end
    check("latency", cyc, inv ? LAT + 1 + BLINK : LAT + 1);
    check("rsp_data", rsp_data, exp_d);
    check("rsp_err", rsp_err, inv);
    if ((inv && led_mode == 1) || (!inv && led_mode == 2)) prot_exp = 1'b1;
    check("prot_err", prot_err, prot_exp);
    check("pins_resp_nop", pins, 0);
    d0 = rsp_data;
    e0 = rsp_err;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = (i % 2 == 0);
      cmd_data  = mk($urandom_range(0, 7), $urandom_range(0, 7), 3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_stable", {rsp_err, rsp_data}, {e0, d0});
      check("bp_not_ready", cmd_ready, 0);
    end
    cmd_valid = (hold > 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_data = '0;
    tick(); tick();
    check("rst_pins", pins, 0);
    check("rst_rsp", {rsp_valid, rsp_err, prot_err, rsp_data}, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", cmd_ready, 1);

    run_cmd(mk(3, 5, 2, 1, 0, 0, 0, 0, 0, 0), 0);
    check("add_3_5_1", rsp_data, 9);
    run_cmd(mk(7, 7, 3, 0, 0, 0, 0, 0, 0, 0), 0);
    check("mult_7_7", rsp_data, 49);
    run_cmd(mk(6, 0, 4, 0, 1, 0, 0, 0, 0, 0), 0);
    check("shift_right", rsp_data, 7);
    run_cmd(mk(2, 3, 6, 0, 0, 0, 0, 0, 0, 0), 0);
    check("inv_op110_err", {rsp_err, rsp_data}, 7'h40);
    run_cmd(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0), 0);
    check("add_1_1", rsp_data, 2);
    run_cmd(mk(4, 2, 2, 0, 0, 0, 1, 0, 0, 0), 0);
    check("redop_add_err", rsp_err, 1);
    run_cmd(mk(5, 6, 3, 0, 0, 0, 0, 0, 0, 0), 5);

    for (int n = 0; n < 30; n++) run_cmd(16'($urandom), $urandom_range(0, 3));

    // Reset during WAIT abandons the command.
    cmd_valid = 1'b1;
    cmd_data  = mk(2, 2, 3, 0, 0, 0, 0, 0, 0, 0);
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_pins", pins, 0);
    check("midrst_valid", rsp_valid, 0);
    rst = 1'b0;
    prot_exp = 1'b0;
    #1;
    check("midrst_ready", cmd_ready, 1);
    for (int i = 0; i < 6; i++) tick();
    check("midrst_no_rsp", rsp_valid, 0);

    // LEDs stuck at zero on an invalid command; prot_err must stick.
    led_mode = 1;
    run_cmd(mk(1, 2, 7, 0, 0, 0, 0, 0, 0, 0), 0);
    check("prot_set", prot_err, 1);
    led_mode = 0;
    run_cmd(mk(2, 2, 2, 1, 0, 0, 0, 0, 0, 0), 1);
    check("prot_sticky", prot_err, 1);
    led_mode = 2;
    run_cmd(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    led_mode = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prot_exp = 1'b0;
    #1;
    check("prot_cleared", prot_err, 0);
    run_cmd(mk(7, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alsu_cmd_driver.md
Name: alsu_cmd_driver

Overview:
- Initiator that drives the ALSU operand/control pins from a packed command word and returns the ALSU result over a valid/ready response channel.
- Sits between the board-level stimulus source (switch sampler or test sequencer) and the ALSU, sharing its clk and rst.
- Decodes invalid commands itself, holds off new commands while the ALSU LED blink runs, and checks that the ALSU LED behaviour matches the decode.

Parameters:
- LATENCY, 2, ALSU cycles from pins driven to result on out.
- BLINK_CYCLES, 16, cycles spent in BLINK after an invalid command before responding.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high; shared with the ALSU.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command; high only in IDLE.
- cmd_data  input  16  command fields:
  - [2:0] A, [5:3] B, [8:6] opcode
  - [9] cin, [10] serial_in, [11] direction
  - [12] red_op_A, [13] red_op_B, [14] bypass_A, [15] bypass_B
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  6  captured ALSU out; 0 when rsp_err=1.
- rsp_err  output  1  command was invalid.
- prot_err  output  1  sticky: ALSU LED behaviour disagreed with the decode.
- alsu_A, alsu_B, alsu_opcode  output  3 each  to the ALSU.
- alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  output  1 each  to the ALSU.
- alsu_out  input  6  ALSU result.
- alsu_leds  input  16  ALSU LEDs.

Behaviour:
- Reset (synchronous; the rst branch takes priority over everything):
  - State goes to IDLE. rsp_valid=0, rsp_data=0, rsp_err=0, prot_err=0. All alsu_* outputs=0 (NOP).
  - cmd_ready goes high on the first cycle after rst deasserts.
  - Reset mid-command abandons the command with no response.
- NOP pin value: all alsu_* outputs are 0. The pins carry NOP in every state except ISSUE and WAIT.
- Invalid decode, computed at accept:
  - opcode is 110 or 111, OR
  - (red_op_A or red_op_B) is 1 and opcode is not 000/001.
- States: IDLE, ISSUE, WAIT, BLINK, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_data and the invalid flag, go to ISSUE.
- ISSUE (1 cycle): the alsu_* pins are driven from the latched command.
- WAIT (LATENCY cycles, counter from 0):
  - The pins keep holding the command. This is mandatory: the ALSU reads direction unregistered during evaluation.
  - Valid command: on the final WAIT edge, sample alsu_out into rsp_data, set rsp_err=0 and go to RESP.
  - Invalid command: go to BLINK after the final WAIT edge.
- BLINK (BLINK_CYCLES cycles): pins at NOP. Then rsp_data=0, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable until rsp_valid&&rsp_ready.
  - On handshake, go to IDLE with rsp_valid=0 on the next cycle.
  - cmd_valid is ignored in this state.
- Timing:
  - Valid command: accept edge to rsp_valid = LATENCY+1 cycles (3 by default).
  - Invalid command: accept edge to rsp_valid = LATENCY+1+BLINK_CYCLES cycles.
  - Best-case throughput: one command per LATENCY+3 cycles.
- LED check (prot_err is sticky and only cleared by rst):
  - Track whether alsu_leds!=0 was seen during ISSUE/WAIT/BLINK.
  - Invalid command with no nonzero LEDs seen: set prot_err when leaving BLINK.
  - Valid command with nonzero LEDs seen: set prot_err when leaving WAIT.
- Width: alsu_out is captured as-is; no extension or checking of the result value.

Test Plan:
- ADD: cmd A=3, B=5, cin=1, opcode=010 → rsp_valid 3 cycles after accept, rsp_data=9, rsp_err=0, prot_err=0.
- MULT and shift:
  - A=7, B=7, opcode=011 → rsp_data=49.
  - Then A=3'b110, serial_in=1, direction=0, opcode=100 → rsp_data=7 (direction held through WAIT).
- Invalid opcode 110:
  - rsp_valid after 19 cycles, rsp_err=1, rsp_data=0, alsu_leds nonzero seen, prot_err=0.
  - Then ADD A=1, B=1, cin=0 → rsp_data=2.
- red_op_A=1 with opcode=010 → handled as invalid, rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles while pulsing cmd_valid with opcode 011 → rsp_valid, rsp_data, rsp_err stable; cmd_ready=0; the second command is not accepted until one cycle after the handshake.
- Reset and protocol error:
  - Assert rst during WAIT → next cycle: pins 0, rsp_valid=0, cmd_ready=1 once rst drops.
  - Tie alsu_leds=0 with opcode=111 → prot_err=1 and it stays 1 until rst.
